led_pwm_sequencer: RTL and testbench

//   Multi-channel LED driver that replaces raw counter-bit outputs with per-channel PWM brightness.

---
 rtl/led_pwm_sequencer.sv | 169 ++++++++++++++++
 tb/tb_led_pwm_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_sequencer.sv
// Multi-channel LED PWM sequencer: per-channel OFF / STATIC / BLINK / BREATHE brightness.
// Latency: led is registered, one clk after pwm_cnt / effective level; cfg_err one clk after the bad write.
// Backpressure: none; cfg_ready rises on the first edge after reset and stays high.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset (release assumed synchronised upstream)
//   cfg_valid / cfg_ready config write handshake
//   cfg_chan              target channel index
//   cfg_mode              00 OFF, 01 STATIC, 10 BLINK, 11 BREATHE
//   cfg_duty              brightness, or breathe peak level
//   cfg_err               one-cycle pulse after a write to a channel index >= CHANNELS
//   led                   registered LED drive, polarity set by ACTIVE_LOW
module led_pwm_sequencer #(
    parameter int  CHANNELS   = 3,
    parameter int  WIDTH      = 8,
    parameter int  PRESCALE   = 48000,
    parameter int  ACTIVE_LOW = 0,
    localparam int CHAN_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CHAN_W-1:0]   cfg_chan,
    input  logic [1:0]          cfg_mode,
    input  logic [WIDTH-1:0]    cfg_duty,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] led
);

    localparam int                 PRESC_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);
    localparam logic [WIDTH-1:0]   LVL_ONE    = WIDTH'(1);
    localparam logic               LED_INV    = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STATIC  = 2'b01,
        MODE_BLINK   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_e;

    // Per-channel state
    mode_e            r_mode     [CHANNELS];
    logic [WIDTH-1:0] r_duty     [CHANNELS];
    logic [WIDTH-1:0] r_level    [CHANNELS];
    logic             r_dir_up   [CHANNELS];
    logic             r_blink_ph [CHANNELS];

    // Shared timebase: PWM edges of all channels are phase-aligned
    logic [PRESC_W-1:0]  r_presc;
    logic [WIDTH-1:0]    r_pwm_cnt;
    logic                r_cfg_ready;
    logic                r_cfg_err;
    logic [CHANNELS-1:0] r_led;

    mode_e            w_mode_nxt     [CHANNELS];
    logic [WIDTH-1:0] w_duty_nxt     [CHANNELS];
    logic [WIDTH-1:0] w_level_nxt    [CHANNELS];
    logic             w_dir_up_nxt   [CHANNELS];
    logic             w_blink_ph_nxt [CHANNELS];
    logic [WIDTH-1:0] w_eff          [CHANNELS];
    logic [CHANNELS-1:0] w_on;

    logic w_tick;
    logic w_xfer;
    logic w_chan_bad;

    assign w_tick     = (r_presc == PRESC_LAST);
    assign w_xfer     = cfg_valid && r_cfg_ready;
    assign w_chan_bad = (32'(cfg_chan) >= 32'(CHANNELS));

    assign cfg_ready = r_cfg_ready;
    assign cfg_err   = r_cfg_err;
    assign led       = r_led;

    // Effective level and raw PWM compare. eff==0 never lights; eff==max lights all but one slot.
    always_comb begin
        w_on = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_eff[ch] = '0;
            case (r_mode[ch])
                MODE_STATIC:  w_eff[ch] = r_duty[ch];
                MODE_BLINK:   w_eff[ch] = r_blink_ph[ch] ? r_duty[ch] : '0;
                MODE_BREATHE: w_eff[ch] = r_level[ch];
                default:      w_eff[ch] = '0;
            endcase
            w_on[ch] = (r_pwm_cnt < w_eff[ch]);
        end
    end

    // Channel next-state. A config write to a channel overrides a coincident tick on that channel.
    always_comb begin
        for (int ch = 0; ch < CHANNELS; ch++) begin
            w_mode_nxt[ch]     = r_mode[ch];
            w_duty_nxt[ch]     = r_duty[ch];
            w_level_nxt[ch]    = r_level[ch];
            w_dir_up_nxt[ch]   = r_dir_up[ch];
            w_blink_ph_nxt[ch] = r_blink_ph[ch];

            if (w_xfer && !w_chan_bad && (cfg_chan == CHAN_W'(ch))) begin
                w_mode_nxt[ch]     = mode_e'(cfg_mode);
                w_duty_nxt[ch]     = cfg_duty;
                w_level_nxt[ch]    = '0;
                w_dir_up_nxt[ch]   = 1'b1;
                w_blink_ph_nxt[ch] = 1'b1;
            end else if (w_tick) begin
                case (r_mode[ch])
                    MODE_BLINK: w_blink_ph_nxt[ch] = ~r_blink_ph[ch];
                    MODE_BREATHE: begin
                        if (r_duty[ch] == '0) begin
                            w_level_nxt[ch]  = '0;
                            w_dir_up_nxt[ch] = 1'b1;
                        end else if (r_dir_up[ch]) begin
                            // Saturating ramp: turn around on the step that lands on the peak
                            if (r_level[ch] < r_duty[ch]) begin
                                w_level_nxt[ch] = r_level[ch] + LVL_ONE;
                                if ((r_level[ch] + LVL_ONE) == r_duty[ch]) begin
                                    w_dir_up_nxt[ch] = 1'b0;
                                end
                            end else begin
                                w_dir_up_nxt[ch] = 1'b0;
                            end
                        end else begin
                            if (r_level[ch] != '0) begin
                                w_level_nxt[ch] = r_level[ch] - LVL_ONE;
                            end
                            if (r_level[ch] <= LVL_ONE) begin
                                w_dir_up_nxt[ch] = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_mode[ch]     <= MODE_OFF;
                r_duty[ch]     <= '0;
                r_level[ch]    <= '0;
                r_dir_up[ch]   <= 1'b1;
                r_blink_ph[ch] <= 1'b1;
            end
            r_presc     <= '0;
            r_pwm_cnt   <= '0;
            r_cfg_ready <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_led       <= {CHANNELS{LED_INV}};
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                r_mode[ch]     <= w_mode_nxt[ch];
                r_duty[ch]     <= w_duty_nxt[ch];
                r_level[ch]    <= w_level_nxt[ch];
                r_dir_up[ch]   <= w_dir_up_nxt[ch];
                r_blink_ph[ch] <= w_blink_ph_nxt[ch];
            end
            r_presc     <= w_tick ? '0 : (r_presc + PRESC_W'(1));
            r_pwm_cnt   <= r_pwm_cnt + LVL_ONE;
            r_cfg_ready <= 1'b1;
            r_cfg_err   <= w_xfer && w_chan_bad;
            r_led       <= w_on ^ {CHANNELS{LED_INV}};
        end
    end

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Bench for led_pwm_sequencer with CHANNELS=3, WIDTH=4, PRESCALE=4.
// Two instances share all inputs: ACTIVE_LOW=0 and ACTIVE_LOW=1.
// A behavioural model pushes the expected {cfg_ready, cfg_err, led} at each edge; tasks pop and compare.
module tb_led_pwm_sequencer;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_chan  = 2'd0;
    logic [1:0] cfg_mode  = 2'd0;
    logic [3:0] cfg_duty  = 4'd0;

    logic       cfg_ready, cfg_err;
    logic [2:0] led;
    logic       cfg_ready_al, cfg_err_al;
    logic [2:0] led_al;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    led_pwm_sequencer #(.CHANNELS(3), .WIDTH(4), .PRESCALE(4), .ACTIVE_LOW(0)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
        .cfg_err(cfg_err), .led(led)
    );

    led_pwm_sequencer #(.CHANNELS(3), .WIDTH(4), .PRESCALE(4), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_al),
        .cfg_chan(cfg_chan), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
        .cfg_err(cfg_err_al), .led(led_al)
    );

    // Reference model state
    logic [1:0] m_mode  [3];
    logic [3:0] m_duty  [3];
    logic [3:0] m_level [3];
    logic       m_up    [3];
    logic       m_ph    [3];
    int         m_presc;
    int         m_pwm;
    logic       m_ready;
    logic       m_err;
    logic [2:0] m_led;

    logic [4:0] exp_q [$];
    logic [4:0] exp_v;

    task automatic model_reset();
        for (int ch = 0; ch < 3; ch++) begin
            m_mode[ch] = 2'd0; m_duty[ch] = 4'd0; m_level[ch] = 4'd0;
            m_up[ch] = 1'b1; m_ph[ch] = 1'b1;
        end
        m_presc = 0; m_pwm = 0; m_ready = 1'b0; m_err = 1'b0; m_led = 3'b000;
        exp_q.delete();
    endtask

    // One clock edge of the spec behaviour, using the inputs held across that edge.
    task automatic model_edge();
        logic       tick, xfer;
        logic [3:0] eff;
        tick = (m_presc == 3);
        xfer = cfg_valid && m_ready;
        for (int ch = 0; ch < 3; ch++) begin
            case (m_mode[ch])
                2'd0:    eff = 4'd0;
                2'd1:    eff = m_duty[ch];
                2'd2:    eff = m_ph[ch] ? m_duty[ch] : 4'd0;
                default: eff = m_level[ch];
            endcase
            m_led[ch] = (m_pwm < 32'(eff));
        end
        m_err = xfer && (cfg_chan >= 2'd3);
        for (int ch = 0; ch < 3; ch++) begin
            if (xfer && (cfg_chan == 2'(ch))) begin
                m_mode[ch] = cfg_mode; m_duty[ch] = cfg_duty;
                m_level[ch] = 4'd0; m_up[ch] = 1'b1; m_ph[ch] = 1'b1;
            end else if (tick) begin
                if (m_mode[ch] == 2'd2) m_ph[ch] = ~m_ph[ch];
                if (m_mode[ch] == 2'd3) begin
                    if (m_up[ch]) begin
                        if (m_level[ch] < m_duty[ch]) m_level[ch] = m_level[ch] + 4'd1;
                        if (m_level[ch] == m_duty[ch]) m_up[ch] = 1'b0;
                    end else begin
                        if (m_level[ch] > 4'd0) m_level[ch] = m_level[ch] - 4'd1;
                        if (m_level[ch] == 4'd0) m_up[ch] = 1'b1;
                    end
                end
            end
        end
        m_ready = 1'b1;
        m_presc = (m_presc + 1) % 4;
        m_pwm   = (m_pwm + 1) % 16;
        exp_q.push_back({m_ready, m_err, m_led});
    endtask

    // Advance one clock: model the edge, then fetch the expectation at the falling edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (exp_q.size() != 0) exp_v = exp_q.pop_front();
        else                   exp_v = 5'bxxxxx;
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (led !== 3'b000)   begin errors++; $display("FAIL reset_led got=%b exp=000", led); end
        checks++; if (led_al !== 3'b111) begin errors++; $display("FAIL reset_led_al got=%b exp=111", led_al); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", cfg_ready); end
        checks++; if (cfg_err !== 1'b0)   begin errors++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
        rst_n = 1'b1;
        step();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", cfg_ready); end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) step();
            checks++;
            if ({cfg_ready, cfg_err, led} !== exp_v) begin
                errors++; $display("FAIL idle cyc=%0d got=%b exp=%b", i, {cfg_ready, cfg_err, led}, exp_v);
            end
        end
    endtask

    task automatic test_static();
        logic [3:0] duties [3];
        int hi, lo_al;
        duties[0] = 4'd5; duties[1] = 4'd0; duties[2] = 4'd15;
        for (int d = 0; d < 3; d++) begin
            cfg_valid = 1'b1; cfg_chan = 2'd1; cfg_mode = 2'b01; cfg_duty = duties[d];
            hi = 0; lo_al = 0;
            for (int i = 0; i < 22; i++) begin
                step();
                if (i == 0) cfg_valid = 1'b0;
                checks++;
                if ({cfg_ready, cfg_err, led} !== exp_v) begin
                    errors++; $display("FAIL static duty=%0d cyc=%0d got=%b exp=%b", duties[d], i, {cfg_ready, cfg_err, led}, exp_v);
                end
                checks++;
                if ({cfg_ready_al, cfg_err_al, led_al} !== (exp_v ^ 5'b00111)) begin
                    errors++; $display("FAIL static_al duty=%0d cyc=%0d got=%b exp=%b", duties[d], i, {cfg_ready_al, cfg_err_al, led_al}, exp_v ^ 5'b00111);
                end
                if (i >= 2 && i < 18) begin
                    if (led[1] === 1'b1)    hi++;
                    if (led_al[1] === 1'b0) lo_al++;
                end
            end
            checks++;
            if (hi != int'(duties[d])) begin errors++; $display("FAIL static_count duty=%0d got=%0d exp=%0d", duties[d], hi, duties[d]); end
            checks++;
            if (lo_al != int'(duties[d])) begin errors++; $display("FAIL static_al_count duty=%0d got=%0d exp=%0d", duties[d], lo_al, duties[d]); end
        end
    endtask

    task automatic test_blink();
        int hi;
        cfg_valid = 1'b1; cfg_chan = 2'd0; cfg_mode = 2'b10; cfg_duty = 4'd15;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 0) cfg_valid = 1'b0;
            checks++;
            if ({cfg_ready, cfg_err, led} !== exp_v) begin
                errors++; $display("FAIL blink cyc=%0d got=%b exp=%b", i, {cfg_ready, cfg_err, led}, exp_v);
            end
            if (i >= 1 && i < 33 && led[0] === 1'b1) hi++;
        end
        // 32 cycles = 4 blink periods, each 4 lit slots; at most one slot of 16 is dark at duty 15
        checks++;
        if (hi < 14 || hi > 16) begin errors++; $display("FAIL blink_count got=%0d exp=14..16", hi); end
    endtask

    task automatic test_breathe();
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_mode = 2'b11; cfg_duty = 4'd3;
        for (int i = 0; i < 60; i++) begin
            step();
            if (i == 0) cfg_valid = 1'b0;
            checks++;
            if ({cfg_ready, cfg_err, led} !== exp_v) begin
                errors++; $display("FAIL breathe cyc=%0d got=%b exp=%b", i, {cfg_ready, cfg_err, led}, exp_v);
            end
        end
    endtask

    task automatic test_error();
        cfg_valid = 1'b1; cfg_chan = 2'd3; cfg_mode = 2'b01; cfg_duty = 4'd15;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_err !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b exp=1", cfg_err); end
        step();
        checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL err_width got=%b exp=0", cfg_err); end
        for (int i = 0; i < 24; i++) begin
            step();
            checks++;
            if ({cfg_ready, cfg_err, led} !== exp_v) begin
                errors++; $display("FAIL err_nochange cyc=%0d got=%b exp=%b", i, {cfg_ready, cfg_err, led}, exp_v);
            end
        end
    endtask

    task automatic test_collision();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            if (m_presc == 3) found = 1'b1;
            else step();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL collision_align got=%0d exp=3", m_presc); end
        cfg_valid = 1'b1; cfg_chan = 2'd2; cfg_mode = 2'b11; cfg_duty = 4'd3;
        for (int i = 0; i < 64; i++) begin
            step();
            if (i == 0) cfg_valid = 1'b0;
            checks++;
            if ({cfg_ready, cfg_err, led} !== exp_v) begin
                errors++; $display("FAIL collision cyc=%0d got=%b exp=%b", i, {cfg_ready, cfg_err, led}, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (led !== 3'b000)    begin errors++; $display("FAIL async_led got=%b exp=000", led); end
        checks++; if (led_al !== 3'b111) begin errors++; $display("FAIL async_led_al got=%b exp=111", led_al); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL async_ready got=%b exp=0", cfg_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({cfg_ready, cfg_err, led} !== exp_v) begin
                errors++; $display("FAIL post_reset cyc=%0d got=%b exp=%b", i, {cfg_ready, cfg_err, led}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_blink();
        test_breathe();
        test_error();
        test_collision();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
